// File: rtl/mem_requester_if.sv
// ---------------------------------------------------------------------------
// mem_requester_if : pipeline request/response and word-memory strobe bus
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface mem_requester_if #(
   parameter int WORD_SIZE = 32
);
   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [WORD_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [WORD_SIZE-1:0] resp_rdata;
   logic [1:0]           resp_status;

   logic                 mem_start;
   logic                 mem_write_enabled;
   logic [WORD_SIZE-1:0] mem_address;
   logic [WORD_SIZE-1:0] mem_input_data;
   logic                 mem_valid;
   logic [WORD_SIZE-1:0] mem_output_data;
   logic                 mem_err_invalid_address;

   // Controller side
   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, resp_ready,
             mem_valid, mem_output_data, mem_err_invalid_address,
      output req_ready, resp_valid, resp_rdata, resp_status,
             mem_start, mem_write_enabled, mem_address, mem_input_data
   );

   // Pipeline plus memory side
   modport master (
      output req_valid, req_write, req_addr, req_wdata, resp_ready,
             mem_valid, mem_output_data, mem_err_invalid_address,
      input  req_ready, resp_valid, resp_rdata, resp_status,
             mem_start, mem_write_enabled, mem_address, mem_input_data
   );
endinterface

`default_nettype wire

// File: rtl/mem_requester.sv
// ---------------------------------------------------------------------------
// mem_requester : single-outstanding load/store initiator for the start-strobed
//                 word memory. Optional read timeout: MEM_REQ_TIMEOUT_EN.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_requester #(
   parameter int WORD_SIZE      = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int TIMEOUT_W      = 5
) (
   input  logic           clk,
   input  logic           reset_n,
   mem_requester_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_STROBE = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   localparam logic [1:0] c_ST_OK      = 2'b00;
   localparam logic [1:0] c_ST_BADADDR = 2'b01;

   generate
      if (TIMEOUT_CYCLES < 2 || (2 ** TIMEOUT_W) <= TIMEOUT_CYCLES) begin : g_bad_timeout_cfg
         $error("mem_requester: TIMEOUT_CYCLES must be >= 2 and < 2**TIMEOUT_W");
      end
   endgenerate

   state_t               r_state, w_state;
   logic                 r_req_ready, w_req_ready;
   logic                 r_resp_valid, w_resp_valid;
   logic [WORD_SIZE-1:0] r_resp_rdata, w_resp_rdata;
   logic [1:0]           r_resp_status, w_resp_status;
   logic                 r_mem_start, w_mem_start;
   logic                 r_mem_we, w_mem_we;
   logic [WORD_SIZE-1:0] r_mem_addr, w_mem_addr;
   logic [WORD_SIZE-1:0] r_mem_wdata, w_mem_wdata;

`ifdef MEM_REQ_TIMEOUT_EN
   localparam logic [1:0]           c_ST_TIMEOUT = 2'b10;
   localparam logic [TIMEOUT_W-1:0] c_CNT_LAST   = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
   logic [TIMEOUT_W-1:0] r_cnt, w_cnt;
`endif

   always_comb begin
      w_state       = r_state;
      w_req_ready   = r_req_ready;
      w_resp_valid  = r_resp_valid;
      w_resp_rdata  = r_resp_rdata;
      w_resp_status = r_resp_status;
      w_mem_start   = r_mem_start;
      w_mem_we      = r_mem_we;
      w_mem_addr    = r_mem_addr;
      w_mem_wdata   = r_mem_wdata;
`ifdef MEM_REQ_TIMEOUT_EN
      w_cnt         = r_cnt;
`endif

      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid && r_req_ready) begin
               w_mem_we    = bus.req_write;
               w_mem_addr  = bus.req_addr;
               w_mem_wdata = bus.req_wdata;
               w_req_ready = 1'b0;
               w_state     = S_SETUP;
            end
         end

         // Address has been on the bus for a full cycle; range error is valid now
         S_SETUP: begin
            w_mem_start = 1'b0;
            if (bus.mem_err_invalid_address) begin
               w_resp_status = c_ST_BADADDR;
               w_resp_rdata  = '0;
               w_resp_valid  = 1'b1;
               w_state       = S_RESP;
            end else begin
               w_mem_start = 1'b1;
               w_state     = S_STROBE;
            end
         end

         S_STROBE: begin
            w_mem_start = 1'b0;
            if (r_mem_we) begin
               w_resp_status = c_ST_OK;
               w_resp_rdata  = '0;
               w_resp_valid  = 1'b1;
               w_state       = S_RESP;
            end else begin
`ifdef MEM_REQ_TIMEOUT_EN
               w_cnt   = '0;
`endif
               w_state = S_WAIT;
            end
         end

         // Data wins over a coincident timeout
         S_WAIT: begin
            w_mem_start = 1'b0;
            if (bus.mem_valid) begin
               w_resp_rdata  = bus.mem_output_data;
               w_resp_status = c_ST_OK;
               w_resp_valid  = 1'b1;
               w_state       = S_RESP;
            end
`ifdef MEM_REQ_TIMEOUT_EN
            else if (r_cnt == c_CNT_LAST) begin
               w_cnt         = r_cnt + 1'b1;
               w_resp_rdata  = '0;
               w_resp_status = c_ST_TIMEOUT;
               w_resp_valid  = 1'b1;
               w_state       = S_RESP;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
`endif
         end

         S_RESP: begin
            if (bus.resp_ready) begin
               w_resp_valid = 1'b0;
               w_req_ready  = 1'b1;
               w_state      = S_IDLE;
            end
         end

         default: begin
            w_mem_start  = 1'b0;
            w_resp_valid = 1'b0;
            w_req_ready  = 1'b1;
            w_state      = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= S_IDLE;
         r_req_ready   <= 1'b1;
         r_resp_valid  <= 1'b0;
         r_resp_rdata  <= '0;
         r_resp_status <= 2'b00;
         r_mem_start   <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
         r_cnt         <= '0;
`endif
      end else begin
         r_state       <= w_state;
         r_req_ready   <= w_req_ready;
         r_resp_valid  <= w_resp_valid;
         r_resp_rdata  <= w_resp_rdata;
         r_resp_status <= w_resp_status;
         r_mem_start   <= w_mem_start;
         r_mem_we      <= w_mem_we;
         r_mem_addr    <= w_mem_addr;
         r_mem_wdata   <= w_mem_wdata;
`ifdef MEM_REQ_TIMEOUT_EN
         r_cnt         <= w_cnt;
`endif
      end
   end

   assign bus.req_ready         = r_req_ready;
   assign bus.resp_valid        = r_resp_valid;
   assign bus.resp_rdata        = r_resp_rdata;
   assign bus.resp_status       = r_resp_status;
   assign bus.mem_start         = r_mem_start;
   assign bus.mem_write_enabled = r_mem_we;
   assign bus.mem_address       = r_mem_addr;
   assign bus.mem_input_data    = r_mem_wdata;

endmodule

`default_nettype wire
